// File: rtl/mem_bus_responder_pkg.sv
// rtl/mem_bus_responder_pkg.sv - shared definitions for the data-memory port responder
//
// Purpose: FSM state encoding, MMIO register offsets and the default MMIO base
// shared by the responder top and its register bank.
// Ports: none (package).

package mem_bus_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Register offsets relative to the MMIO base address.
  localparam int SW_OFF  = 0;
  localparam int LED_OFF = 1;
  localparam int CNT_OFF = 2;
  localparam int SCR_OFF = 3;

  localparam logic [7:0] DEF_MMIO_BASE = 8'hF0;

endpackage

// File: rtl/mem_bus_responder_if.sv
// rtl/mem_bus_responder_if.sv - processor data-memory request/response bus
//
// Purpose: groups the processor-side request and response signals.
// Signals:
//   req    request strobe (master -> slave)
//   wren   1 = write, 0 = read (master -> slave)
//   addr   request address (master -> slave)
//   wdata  write data (master -> slave)
//   ready  one-cycle completion pulse (slave -> master)
//   rdata  read data, zero outside the ready pulse (slave -> master)

interface mem_bus_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic              req;
  logic              wren;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wren, addr, wdata,
    input  ready, rdata
  );

  modport slave (
    input  req, wren, addr, wdata,
    output ready, rdata
  );

endinterface

// File: rtl/mem_bus_responder_mmio_regs.sv
// rtl/mem_bus_responder_mmio_regs.sv - MMIO register bank for the memory responder
//
// Purpose: switch synchronizer, LED, free-running counter and scratch registers
// with a combinational read mux.
// Ports:
//   clock    system clock, rising edge
//   reset    asynchronous reset, active low
//   wr_en    one-cycle register write strobe
//   offset   register offset from the MMIO base
//   wdata    register write data
//   rdata    read data for the addressed register (0 for unmapped offsets)
//   sw_in    asynchronous switch inputs
//   led_out  LED register

module mem_bus_responder_mmio_regs
  import mem_bus_responder_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] offset,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] sw_in,
  output logic [DATA_W-1:0] led_out
);

  localparam logic [DATA_W-1:0] CNT_INC = DATA_W'(1);

  logic [DATA_W-1:0] sw_meta;
  logic [DATA_W-1:0] sw_sync;
  logic [DATA_W-1:0] cnt_q;
  logic [DATA_W-1:0] scr_q;

  logic hit_sw;
  logic hit_led;
  logic hit_cnt;
  logic hit_scr;

  assign hit_sw  = (offset == ADDR_W'(SW_OFF));
  assign hit_led = (offset == ADDR_W'(LED_OFF));
  assign hit_cnt = (offset == ADDR_W'(CNT_OFF));
  assign hit_scr = (offset == ADDR_W'(SCR_OFF));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
      led_out <= '0;
      cnt_q   <= '0;
      scr_q   <= '0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
      if (wr_en && hit_led) begin
        led_out <= wdata;
      end
      // A counter write takes priority over that cycle's increment.
      if (wr_en && hit_cnt) begin
        cnt_q <= wdata;
      end else begin
        cnt_q <= cnt_q + CNT_INC;
      end
      if (wr_en && hit_scr) begin
        scr_q <= wdata;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (hit_sw) begin
      rdata = sw_sync;
    end else if (hit_led) begin
      rdata = led_out;
    end else if (hit_cnt) begin
      rdata = cnt_q;
    end else if (hit_scr) begin
      rdata = scr_q;
    end
  end

endmodule

// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - wait-stated slave responder for the data-memory port
//
// Purpose: accepts single read/write requests, inserts WAIT_CYCLES wait states,
// routes the access to an external synchronous RAM (below MMIO_BASE) or to the
// MMIO register bank, and answers with a one-cycle ready pulse.
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous reset, active low
//   bus        processor request/response bus (slave side)
//   ram_addr   registered RAM address
//   ram_wren   RAM write strobe
//   ram_wdata  RAM write data
//   ram_q      RAM read data, valid one cycle after ram_addr is clocked
//   sw_in      asynchronous switch inputs
//   led_out    LED register

module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 8,
  parameter int                WAIT_CYCLES = 1,
  parameter logic [ADDR_W-1:0] MMIO_BASE   = ADDR_W'(DEF_MMIO_BASE)
) (
  input  logic                 clock,
  input  logic                 reset,
  mem_bus_responder_if.slave   bus,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic                 ram_wren,
  output logic [DATA_W-1:0]    ram_wdata,
  input  logic [DATA_W-1:0]    ram_q,
  input  logic [DATA_W-1:0]    sw_in,
  output logic [DATA_W-1:0]    led_out
);

  localparam int              CNT_W     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] WAIT_ONE  = CNT_W'(1);

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mmio_sel_q;
  logic [DATA_W-1:0] mmio_q;
  logic              ready_q;
  logic [DATA_W-1:0] rdata_q;

  logic [ADDR_W-1:0] acc_addr;
  logic              acc_wr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_mmio;

  logic [ADDR_W-1:0] mmio_off;
  logic              mmio_we;
  logic [DATA_W-1:0] mmio_rd;

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;

  // With no wait states the RAM is driven on the acceptance edge itself, so
  // the access source is the live bus in IDLE and the latched request after.
  assign acc_addr  = (state == ST_IDLE) ? bus.addr  : addr_q;
  assign acc_wr    = (state == ST_IDLE) ? bus.wren  : wr_q;
  assign acc_wdata = (state == ST_IDLE) ? bus.wdata : wdata_q;
  assign acc_mmio  = (acc_addr >= MMIO_BASE);

  // Register bank sees the latched request; writes land on the ACCESS edge.
  assign mmio_off = addr_q - MMIO_BASE;
  assign mmio_we  = (state == ST_ACCESS) && wr_q && mmio_sel_q;

  mem_bus_responder_mmio_regs #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mmio_regs (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (mmio_we),
    .offset  (mmio_off),
    .wdata   (wdata_q),
    .rdata   (mmio_rd),
    .sw_in   (sw_in),
    .led_out (led_out)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      mmio_sel_q <= 1'b0;
      mmio_q     <= '0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      ram_addr   <= '0;
      ram_wren   <= 1'b0;
      ram_wdata  <= '0;
    end else begin
      // Pulse-type outputs default low every cycle.
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      ram_wren <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            addr_q     <= bus.addr;
            wr_q       <= bus.wren;
            wdata_q    <= bus.wdata;
            mmio_sel_q <= acc_mmio;
            wait_cnt   <= WAIT_LOAD;
            if (WAIT_CYCLES > 0) begin
              state <= ST_WAIT;
            end else begin
              state <= ST_ACCESS;
              if (!acc_mmio) begin
                ram_addr <= acc_addr;
                ram_wren <= acc_wr;
                if (acc_wr) begin
                  ram_wdata <= acc_wdata;
                end
              end
            end
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - WAIT_ONE;
          if (wait_cnt == WAIT_ONE) begin
            state <= ST_ACCESS;
            if (!acc_mmio) begin
              ram_addr <= acc_addr;
              ram_wren <= acc_wr;
              if (acc_wr) begin
                ram_wdata <= acc_wdata;
              end
            end
          end
        end
        ST_ACCESS: begin
          state <= ST_RESP;
          if (mmio_sel_q && !wr_q) begin
            mmio_q <= mmio_rd;
          end
        end
        ST_RESP: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
          if (!wr_q) begin
            rdata_q <= mmio_sel_q ? mmio_q : ram_q;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// tb/tb_mem_bus_responder.sv - self-checking bench for mem_bus_responder

module tb_mem_bus_responder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;
  int   cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  mem_bus_responder_if #(.ADDR_W(8), .DATA_W(8)) if1 ();
  mem_bus_responder_if #(.ADDR_W(8), .DATA_W(8)) if0 ();

  logic [7:0] ram_addr1, ram_wdata1, ram_q1, led_out1;
  logic       ram_wren1;
  logic [7:0] ram_addr0, ram_wdata0, ram_q0, led_out0;
  logic       ram_wren0;
  logic [7:0] sw;

  mem_bus_responder #(
    .ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(1), .MMIO_BASE(8'hF0)
  ) u_dut1 (
    .clock(clock), .reset(reset), .bus(if1),
    .ram_addr(ram_addr1), .ram_wren(ram_wren1), .ram_wdata(ram_wdata1),
    .ram_q(ram_q1), .sw_in(sw), .led_out(led_out1)
  );

  mem_bus_responder #(
    .ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(0), .MMIO_BASE(8'hF0)
  ) u_dut0 (
    .clock(clock), .reset(reset), .bus(if0),
    .ram_addr(ram_addr0), .ram_wren(ram_wren0), .ram_wdata(ram_wdata0),
    .ram_q(ram_q0), .sw_in(sw), .led_out(led_out0)
  );

  // External synchronous single-port RAMs
  logic [7:0] ram1 [256];
  logic [7:0] ram0 [256];
  always @(posedge clock) begin
    if (ram_wren1) ram1[ram_addr1] <= ram_wdata1;
    ram_q1 <= ram1[ram_addr1];
    if (ram_wren0) ram0[ram_addr0] <= ram_wdata0;
    ram_q0 <= ram0[ram_addr0];
  end

  int wren_cnt1 = 0;
  always @(negedge clock) if (ram_wren1 === 1'b1) wren_cnt1 <= wren_cnt1 + 1;

  // Reference model state
  int         n_asserts = 0;
  int         n_fail = 0;
  logic [7:0] ref_mem [256];
  logic [7:0] led_m, scr_m, cnt_val;
  int         cnt_anc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counter value seen by a read whose ready pulse appears after posedge pr:
  // the ACCESS cycle follows posedge pr-2.
  function automatic logic [7:0] model_read(input logic [7:0] a, input int pr);
    logic [7:0] off;
    if (a < 8'hF0) return ref_mem[a];
    off = a - 8'hF0;
    case (off)
      8'd0:    return sw;
      8'd1:    return led_m;
      8'd2:    return 8'(int'(cnt_val) + (pr - 2 - cnt_anc));
      8'd3:    return scr_m;
      default: return 8'h00;
    endcase
  endfunction

  // Issue one request on dut1 from a negedge; returns at the negedge where ready is seen.
  task automatic txn(input logic wr, input logic [7:0] a, input logic [7:0] d,
                     output logic [7:0] rd, output int pr);
    int  c_acc;
    bit  seen;
    if1.req = 1'b1; if1.wren = wr; if1.addr = a; if1.wdata = d;
    c_acc = cyc + 1;
    seen = 1'b0; rd = 8'h00; pr = 0;
    for (int n = 0; n < 12 && !seen; n++) begin
      @(negedge clock);
      if1.req = 1'b0;
      if (if1.ready === 1'b1) begin
        seen = 1'b1; rd = if1.rdata; pr = cyc;
      end else begin
        check("rdata_when_not_ready", if1.rdata, 8'h00);
      end
    end
    check("ready_seen", seen, 1);
    if (seen) check("latency", pr - c_acc, 3);
  endtask

  task automatic do_op(input logic wr, input logic [7:0] a, input logic [7:0] d,
                       output logic [7:0] rd);
    int         w0, pr;
    logic [7:0] off;
    w0 = wren_cnt1;
    txn(wr, a, d, rd, pr);
    if (wr) begin
      check("write_rdata", rd, 8'h00);
      if (a < 8'hF0) ref_mem[a] = d;
      else begin
        off = a - 8'hF0;
        case (off)
          8'd1: led_m = d;
          8'd2: begin cnt_val = d; cnt_anc = pr - 1; end
          8'd3: scr_m = d;
          default: ;
        endcase
      end
    end else begin
      check("read_data", rd, model_read(a, pr));
    end
    check("led_out", led_out1, led_m);
    check("ram_wren_cycles", wren_cnt1 - w0, (wr && a < 8'hF0) ? 1 : 0);
  endtask

  initial begin
    logic [7:0] rd, a, d;
    logic       wr;
    int         w0, c0, pulses;
    int         pt [3];
    logic [7:0] exp0;

    for (int i = 0; i < 256; i++) begin
      ram1[i] = 8'(i * 7 + 3);
      ram0[i] = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    reset = 1'b0;
    if1.req = 1'b0; if1.wren = 1'b0; if1.addr = 8'h00; if1.wdata = 8'h00;
    if0.req = 1'b0; if0.wren = 1'b0; if0.addr = 8'h00; if0.wdata = 8'h00;
    sw = 8'h00;
    led_m = 8'h00; scr_m = 8'h00; cnt_val = 8'h00; cnt_anc = 0;

    repeat (3) @(negedge clock);
    check("reset_ready", if1.ready, 0);
    check("reset_rdata", if1.rdata, 8'h00);
    check("reset_led", led_out1, 8'h00);
    check("reset_ram_wren", ram_wren1, 0);
    check("reset_ram_addr", ram_addr1, 8'h00);

    reset = 1'b1; cnt_anc = cyc; cnt_val = 8'h00;
    @(negedge clock);
    do_op(1'b0, 8'hF2, 8'h00, rd);
    check("cnt_after_reset", rd, 8'h03);

    // RAM write then read
    do_op(1'b1, 8'h12, 8'hA5, rd);
    do_op(1'b0, 8'h12, 8'h00, rd);
    check("ram_readback", rd, 8'hA5);

    // LED and unmapped MMIO
    do_op(1'b1, 8'hF1, 8'h3C, rd);
    check("led_written", led_out1, 8'h3C);
    do_op(1'b0, 8'hF1, 8'h00, rd);
    check("led_readback", rd, 8'h3C);
    do_op(1'b1, 8'hF5, 8'h77, rd);
    do_op(1'b0, 8'hF5, 8'h00, rd);
    check("unmapped_read", rd, 8'h00);

    // Counter load and wrap
    do_op(1'b1, 8'hF2, 8'hFE, rd);
    do_op(1'b0, 8'hF2, 8'h00, rd);
    check("cnt_wrap", rd, 8'h01);

    // Scratch and switches
    do_op(1'b1, 8'hF3, 8'h5A, rd);
    do_op(1'b0, 8'hF3, 8'h00, rd);
    sw = 8'h9C;
    repeat (3) @(negedge clock);
    do_op(1'b0, 8'hF0, 8'h00, rd);
    check("sw_read", rd, 8'h9C);

    // Randomized traffic against the model
    for (int k = 0; k < 40; k++) begin
      if (k % 8 == 0) begin
        sw = 8'($urandom);
        repeat (3) @(negedge clock);
      end
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 239)) : 8'($urandom_range(240, 255));
      d  = 8'($urandom);
      do_op(wr, a, d, rd);
    end

    // Reset during WAIT of a RAM write
    do_op(1'b1, 8'hF1, 8'hC3, rd);
    do_op(1'b1, 8'hF3, 8'h81, rd);
    w0 = wren_cnt1;
    if1.req = 1'b1; if1.wren = 1'b1; if1.addr = 8'h20; if1.wdata = ~ref_mem[8'h20];
    @(negedge clock);
    if1.req = 1'b0;
    reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clock);
      check("midreset_ready", if1.ready, 0);
      check("midreset_ram_wren", ram_wren1, 0);
    end
    check("midreset_led", led_out1, 8'h00);
    check("midreset_rdata", if1.rdata, 8'h00);
    reset = 1'b1; cnt_anc = cyc; cnt_val = 8'h00; led_m = 8'h00; scr_m = 8'h00;
    check("midreset_no_write", wren_cnt1 - w0, 0);
    @(negedge clock);
    do_op(1'b0, 8'h20, 8'h00, rd);
    do_op(1'b0, 8'hF2, 8'h00, rd);
    do_op(1'b0, 8'hF1, 8'h00, rd);
    do_op(1'b0, 8'hF3, 8'h00, rd);
    check("scratch_cleared", rd, 8'h00);

    // Back-to-back requests with no wait states
    exp0 = 8'(32'h40 * 7 + 3);
    if0.req = 1'b1; if0.wren = 1'b0; if0.addr = 8'h40;
    c0 = cyc + 1; pulses = 0;
    pt[0] = -1; pt[1] = -1; pt[2] = -1;
    for (int n = 0; n < 14; n++) begin
      @(negedge clock);
      if (if0.ready === 1'b1) begin
        if (pulses < 3) pt[pulses] = cyc - c0;
        pulses++;
        check("b2b_rdata", if0.rdata, exp0);
        if (pulses == 3) if0.req = 1'b0;
      end
    end
    check("b2b_pulses", pulses, 3);
    check("b2b_pulse0", pt[0], 2);
    check("b2b_pulse1", pt[1], 5);
    check("b2b_pulse2", pt[2], 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
Slave-side responder for the processor's data-memory port. It accepts single read/write requests (address, write enable, write data), applies a programmable wait-state delay and returns read data with a one-cycle ready pulse. Addresses below MMIO_BASE go to an external synchronous single-port RAM. Addresses at or above MMIO_BASE hit a small register bank: switches, LEDs, cycle counter and scratch.

Parameters:
ADDR_W, 8, request address width
DATA_W, 8, data width
WAIT_CYCLES, 1, extra wait-state cycles inserted before each access (0 allowed)
MMIO_BASE, 8'hF0, first address decoded as MMIO; all higher addresses are MMIO

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  asynchronous reset, active-low (0 = reset asserted)
req  input  1  request strobe from processor
wren  input  1  1 = write, 0 = read; sampled with req
addr  input  ADDR_W  request address; sampled with req
wdata  input  DATA_W  write data; sampled with req
ready  output  1  one-cycle completion pulse
rdata  output  DATA_W  read data; valid only while ready=1, otherwise 0
ram_addr  output  ADDR_W  RAM address (registered)
ram_wren  output  1  RAM write strobe
ram_wdata  output  DATA_W  RAM write data
ram_q  input  DATA_W  RAM read data, valid one cycle after ram_addr is clocked
sw_in  input  DATA_W  asynchronous switch inputs
led_out  output  DATA_W  LED register

Behaviour:
- Reset (reset=0, asynchronous) clears the following; RAM contents are untouched:
  - FSM to IDLE; ready=0, rdata=0, ram_wren=0, ram_addr=0, ram_wdata=0.
  - led_out=0, cycle counter=0, scratch=0, switch synchronizer=0.
- FSM states: IDLE, WAIT, ACCESS, RESP.
  - IDLE: on req=1, latch addr/wren/wdata and load the wait counter with WAIT_CYCLES. Go to WAIT if WAIT_CYCLES>0, else ACCESS. With req=0, stay in IDLE.
  - WAIT: decrement the counter; go to ACCESS when it reaches 1 (exactly WAIT_CYCLES cycles spent in WAIT).
  - ACCESS, RAM region: ram_addr=latched addr. For writes, ram_wren=1 and ram_wdata=latched wdata for this single cycle.
  - ACCESS, MMIO region: perform the register write, or capture the MMIO read value into mmio_q.
  - RESP: ready=1 for exactly one cycle. rdata = ram_q (RAM read), mmio_q (MMIO read), or 0 (write). Next state is always IDLE.
- Latency: acceptance edge to ready = WAIT_CYCLES+2 cycles, identical for reads, writes, RAM and MMIO.
- Handshake:
  - req is sampled only in IDLE. Deasserting req mid-transaction does not abort; the access completes and ready still pulses.
  - req held high through RESP starts a new transaction in the following IDLE cycle. The minimum spacing is one IDLE cycle between ready pulses.
- MMIO map (offset from MMIO_BASE):
  - +0 SW: read-only; returns the 2-flop-synchronized sw_in.
  - +1 LED: read/write; led_out updates on the ACCESS edge.
  - +2 CNT: free-running 8-bit counter, +1 every cycle, wraps FF->00. A write loads wdata and wins over the increment that cycle. A read returns the value at the ACCESS cycle.
  - +3 SCRATCH: read/write.
  - Other MMIO offsets: read 0, write ignored. ram_wren is never asserted for MMIO addresses.
- Width rules:
  - The wait counter is clog2(WAIT_CYCLES+1) bits, minimum 1.
  - All address compares are unsigned.
- Reset mid-transaction (any state): immediate return to IDLE. No ready pulse is issued and no pending write is performed. A RAM write already clocked in ACCESS stands.

Decomposition:
- Shared package/include mem_bus_defs:
  - FSM state encodings (2-bit).
  - MMIO offsets SW_OFF=0, LED_OFF=1, CNT_OFF=2, SCR_OFF=3.
  - Default MMIO_BASE.
- One sub-module, mmio_regs: switch synchronizer, LED/CNT/SCRATCH registers and read mux. It takes the write strobe, offset and wdata, and returns read data.
- The FSM and RAM drive stay in mem_bus_responder.

Test Plan:
1. Hold reset=0 mid-run, then release -> ready=0, rdata=00, led_out=00, ram_wren=0; CNT reads 00 on the first access (+ elapsed cycles).
2. WAIT_CYCLES=1: write addr 0x12 data 0xA5, then read 0x12 -> ram_wren high exactly one cycle. Each ready pulses 3 cycles after acceptance; read rdata=A5 during ready, 00 otherwise.
3. Write 0xF1<-0x3C, then read 0xF1 -> led_out=3C from the ACCESS edge and readback=3C. Write 0xF5<-0x77, then read 0xF5 -> returns 00; ram_wren never asserted.
4. Write 0xF2<-0xFE, then read 0xF2 -> value = FE+elapsed cycles mod 256; check wrap through 00.
5. req held high for three transactions, WAIT_CYCLES=0 -> ready pulses at cycles 2, 5, 8 after the first acceptance.
6. Assert reset during WAIT of a write to 0x20 -> no ready pulse, ram_wren stays 0, RAM[0x20] unchanged; FSM accepts a new request after release.
